// File: rtl/riscv_mem_responder_pkg.sv
// Shared widths, types and helpers for the tagged memory responder.
// Data blocks are MEM_DATA_BITS wide with one mask bit per byte.
package riscv_mem_responder_pkg;

  localparam int MEM_ADDR_BITS  = 26;
  localparam int MEM_DATA_BITS  = 128;
  localparam int MEM_TAG_BITS   = 5;
  localparam int MEM_DATA_BYTES = MEM_DATA_BITS / 8;

  typedef logic [MEM_ADDR_BITS-1:0]  mem_addr_t;
  typedef logic [MEM_DATA_BITS-1:0]  mem_data_t;
  typedef logic [MEM_TAG_BITS-1:0]   mem_tag_t;
  typedef logic [MEM_DATA_BYTES-1:0] mem_mask_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_e;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Request/data/response bundle between a requester and the responder.
// master drives requests, slave is the memory side.
interface riscv_mem_responder_if;
  import riscv_mem_responder_pkg::*;

  logic      mem_req_valid;
  logic      mem_req_ready;
  logic      mem_req_rw;
  mem_addr_t mem_req_addr;
  mem_tag_t  mem_req_tag;
  logic      mem_req_data_valid;
  logic      mem_req_data_ready;
  mem_data_t mem_req_data_bits;
  mem_mask_t mem_req_data_mask;
  logic      mem_resp_valid;
  mem_tag_t  mem_resp_tag;
  mem_data_t mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw,
    output mem_req_addr, mem_req_tag,
    output mem_req_data_valid,
    output mem_req_data_bits,
    output mem_req_data_mask,
    input  mem_req_ready,
    input  mem_req_data_ready,
    input  mem_resp_valid,
    input  mem_resp_tag, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw,
    input  mem_req_addr, mem_req_tag,
    input  mem_req_data_valid,
    input  mem_req_data_bits,
    input  mem_req_data_mask,
    output mem_req_ready,
    output mem_req_data_ready,
    output mem_resp_valid,
    output mem_resp_tag, mem_resp_data
  );
endinterface

// File: rtl/riscv_mem_resp_pipe.sv
// Fixed-depth valid/tag/data shift pipeline for read responses.
// Output is the last stage, so a load at edge t appears LATENCY cycles on.
module riscv_mem_resp_pipe #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [TAG_W-1:0]   tag [LATENCY];
  logic [DATA_W-1:0]  dat [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag[i] <= '0;
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      tag[0] <= in_tag;
      dat[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_tag   = tag[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/riscv_mem_responder.sv
// Block memory responder: pipelined tagged reads, two-phase masked writes.
// Define MEM_REQ_THROTTLE_EN to drop mem_req_ready one cycle in eight.
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input logic                  clk,
  input logic                  reset,
  riscv_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  mem_data_t             mem [DEPTH];
  state_e                state;
  logic [DEPTH_LOG2-1:0] widx;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  thr_ok;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  data_fire;
  logic                  unused_addr;

  // upper address bits alias onto the same block
  assign idx = bus.mem_req_addr[DEPTH_LOG2-1:0];
  assign unused_addr =
    ^bus.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2];

`ifdef MEM_REQ_THROTTLE_EN
  logic [2:0] thr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) thr_cnt <= 3'd0;
    else       thr_cnt <= thr_cnt + 3'd1;
  end

  assign thr_ok = (thr_cnt != 3'd7);
`else
  assign thr_ok = 1'b1;
`endif

  assign bus.mem_req_ready =
    !reset && (state == IDLE) && thr_ok;
  assign bus.mem_req_data_ready =
    !reset && (state == WDATA);

  assign rd_fire = bus.mem_req_valid &&
    bus.mem_req_ready && !bus.mem_req_rw;
  assign wr_fire = bus.mem_req_valid &&
    bus.mem_req_ready && bus.mem_req_rw;
  assign data_fire = bus.mem_req_data_valid &&
    bus.mem_req_data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      widx  <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): if (wr_fire) begin
          widx  <= idx;
          state <= WDATA;
        end
        (state == WDATA): if (data_fire)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (data_fire) begin
      for (int b = 0; b < MEM_DATA_BYTES; b++) begin
        if (bus.mem_req_data_mask[b])
          mem[widx][b*8 +: 8] <=
            bus.mem_req_data_bits[b*8 +: 8];
      end
    end
  end

  riscv_mem_resp_pipe #(
    .LATENCY (LATENCY),
    .TAG_W   (MEM_TAG_BITS),
    .DATA_W  (MEM_DATA_BITS)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_fire),
    .in_tag    (bus.mem_req_tag),
    .in_data   (mem[idx]),
    .out_valid (bus.mem_resp_valid),
    .out_tag   (bus.mem_resp_tag),
    .out_data  (bus.mem_resp_data)
  );

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed + random bench for riscv_mem_responder.
// Reference: byte-array memory model plus a due-cycle response queue.
module tb_riscv_mem_responder;
  import riscv_mem_responder_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  typedef struct {
    int        due;
    mem_tag_t  tag;
    mem_data_t data;
  } exp_t;

  logic      clk = 1'b0;
  logic      reset;
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  exp_t      q[$];
  mem_data_t model [DEPTH];
  logic      ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_mem_responder_if bus();

  riscv_mem_responder #(
    .DEPTH_LOG2 (8),
    .LATENCY    (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic mem_data_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // response checker: valid exactly on due cycles, in order
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("resp_valid", {127'd0, bus.mem_resp_valid},
          {127'd0, ev});
      if (ev) begin
        chk("resp_tag", {123'd0, bus.mem_resp_tag},
            {123'd0, q[0].tag});
        chk("resp_data", bus.mem_resp_data, q[0].data);
        void'(q.pop_front());
      end
    end
  end

  task automatic idle();
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_data_valid = 1'b0;
  endtask

  task automatic rd(input mem_addr_t a, input mem_tag_t t);
    bit done = 1'b0;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = a;
    bus.mem_req_tag   = t;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.mem_req_ready === 1'b1) begin
        q.push_back('{cyc + LAT, t, model[a % DEPTH]});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("rd_accept", {127'd0, done}, 128'd1);
  endtask

  task automatic wr(input mem_addr_t a,
                    input mem_data_t d,
                    input mem_mask_t m);
    bit done = 1'b0;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b1;
    bus.mem_req_addr  = a;
    bus.mem_req_tag   = '0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = (bus.mem_req_ready === 1'b1);
      @(posedge clk); #1;
    end
    chk("wr_accept", {127'd0, done}, 128'd1);
    bus.mem_req_valid = 1'b0;
    @(negedge clk);
    chk("wdata_ready", {127'd0, bus.mem_req_ready}, 128'd0);
    chk("wdata_dready", {127'd0, bus.mem_req_data_ready},
        128'd1);
    @(posedge clk); #1;
    bus.mem_req_data_valid = 1'b1;
    bus.mem_req_data_bits  = d;
    bus.mem_req_data_mask  = m;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.mem_req_data_ready === 1'b1) begin
        for (int b = 0; b < MEM_DATA_BYTES; b++)
          if (m[b]) model[a % DEPTH][b*8 +: 8] = d[b*8 +: 8];
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("wdata_accept", {127'd0, done}, 128'd1);
    bus.mem_req_data_valid = 1'b0;
  endtask

  task automatic rst(input int n);
    reset = 1'b1;
    q.delete();
    repeat (n) @(negedge clk);
    chk("rst_ready", {127'd0, bus.mem_req_ready}, 128'd0);
    chk("rst_dready", {127'd0, bus.mem_req_data_ready}, 128'd0);
    chk("rst_rvalid", {127'd0, bus.mem_resp_valid}, 128'd0);
    chk("rst_rtag", {123'd0, bus.mem_resp_tag}, 128'd0);
    chk("rst_rdata", bus.mem_resp_data, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    mem_data_t nd;
    reset = 1'b1;
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_rw         = 1'b0;
    bus.mem_req_addr       = '0;
    bus.mem_req_tag        = '0;
    bus.mem_req_data_valid = 1'b0;
    bus.mem_req_data_bits  = '0;
    bus.mem_req_data_mask  = '0;

    rst(3);
`ifdef MEM_REQ_THROTTLE_EN
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("throttle_ready", {127'd0, bus.mem_req_ready},
          {127'd0, (k % 8) != 7});
    end
    @(posedge clk); #1;
`else
    @(negedge clk);
    chk("idle_ready", {127'd0, bus.mem_req_ready}, 128'd1);
    chk("idle_dready", {127'd0, bus.mem_req_data_ready},
        128'd0);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < DEPTH; i++)
      wr(mem_addr_t'(i), rnd128(), '1);

    rd(26'h05, 5'd3); idle(); drain();

    wr(26'h10, {16{8'hA5}}, 16'hFFFF);
    rd(26'h10, 5'd1); idle(); drain();

    wr(26'h10, '0, 16'h0001);
    rd(26'h10, 5'd2); idle(); drain();

    // stray data beat while idle must not write
    bus.mem_req_data_valid = 1'b1;
    bus.mem_req_data_bits  = rnd128();
    bus.mem_req_data_mask  = '1;
    repeat (2) @(posedge clk);
    #1;
    idle();
    rd(26'h10, 5'd4); idle(); drain();

    rd(26'h01, 5'd0);
    rd(26'h02, 5'd1);
    rd(26'h03, 5'd2);
    idle(); drain();

    rd(26'h30, 5'd5); idle();
    wr(26'h30, rnd128(), '1);
    rd(26'h30, 5'd6); idle(); drain();

    rd(26'h20, 5'd7); idle();
    @(posedge clk); #1;
    rst(2);
    drain();
    rd(26'h20, 5'd8); idle(); drain();

    // write abandoned by reset between address and data
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b1;
    bus.mem_req_addr  = 26'h40;
    @(posedge clk); #1;
    bus.mem_req_valid      = 1'b0;
    nd = ~model[8'h40];
    bus.mem_req_data_valid = 1'b1;
    bus.mem_req_data_bits  = nd;
    bus.mem_req_data_mask  = '1;
    rst(1);
    idle();
    rd(26'h40, 5'd9); idle(); drain();

    for (int i = 0; i < 80; i++) begin
      mem_addr_t a;
      a = mem_addr_t'($urandom);
      if ($urandom_range(0, 2) == 0)
        wr(a, rnd128(), mem_mask_t'($urandom));
      else
        rd(a, mem_tag_t'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle(); drain();

    chk("queue_empty", {96'd0, q.size()}, 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
